config_loader: RTL and testbench

Bitstream loader that drives the serial configuration chain of the fabric. It accepts configuration words from the host over a valid/ready stream, clears the chain, then shifts the words bit-serially into the first tile's `config_in` using `config_enable`. It pulses `done` when exactly `CHAIN_LENGTH` bits have been shifted. It sits between the host interface and the head of the tile configuration chain.

---
 rtl/config_loader_pkg.sv | 16 +
 rtl/config_bit_serializer.sv | 52 +++++
 rtl/config_loader.sv | 111 +++++++++++
 tb/tb_config_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
// Shared state encoding and sizing helper for the configuration-chain loader.
package config_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } loader_state_t;

  function automatic int unsigned words_needed(input int unsigned chain, input int unsigned width);
    return (chain + width - 1) / width;
  endfunction

endpackage

// File: rtl/config_bit_serializer.sv
// Word shift register and per-word bit counter; presents the current bit on a flop.
module config_bit_serializer #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned CW         = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic [CW-1:0]         load_count,
  input  logic                  shift,
  output logic                  bit_out,
  output logic                  empty
);

  logic [WORD_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  out_q, out_d;

  // Bit 0 goes straight to the output flop; the register holds the bits still to come.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (load) begin
      out_d = load_data[0];
      sr_d  = {1'b0, load_data[WORD_WIDTH-1:1]};
      cnt_d = load_count;
    end else if (shift && cnt_q != '0) begin
      out_d = (cnt_q > CW'(1)) ? sr_q[0] : 1'b0;
      sr_d  = {1'b0, sr_q[WORD_WIDTH-1:1]};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign bit_out = out_q;
  // The bit now on bit_out is the last one of the word (or none is left).
  assign empty   = (cnt_q <= CW'(1));

endmodule

// File: rtl/config_loader.sv
// Loads host configuration words bit-serially into the fabric configuration chain.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LENGTH = 36,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned RW = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned CW = $clog2(WORD_WIDTH + 1);
  localparam int unsigned KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  loader_state_t state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [KW-1:0] clr_q, clr_d;
  logic          ready_q, enable_q, nreset_q, busy_q, done_q;
  logic          accept, ser_shift, ser_empty;
  logic [CW-1:0] load_count;

  assign accept = ready_q && word_valid && !abort;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    clr_d     = clr_q;
    ser_shift = 1'b0;
    if (32'(rem_q) >= WORD_WIDTH) load_count = CW'(WORD_WIDTH);
    else                          load_count = CW'(rem_q);
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_CLEAR;
          clr_d   = KW'(CLEAR_CYCLES - 1);
        end
      end
      ST_CLEAR: begin
        rem_d = RW'(CHAIN_LENGTH);
        if (clr_q == '0) state_d = ST_LOAD;
        else             clr_d   = clr_q - KW'(1);
      end
      ST_LOAD: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_shift = 1'b1;
        if (rem_q != '0) rem_d = rem_q - RW'(1);
        if (ser_empty) state_d = (rem_q <= RW'(1)) ? ST_DONE : ST_LOAD;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  // Outputs are registered from the next state so each flop matches the state it labels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      clr_q    <= '0;
      ready_q  <= 1'b0;
      enable_q <= 1'b0;
      nreset_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      clr_q    <= clr_d;
      ready_q  <= (state_d == ST_LOAD);
      enable_q <= (state_d == ST_SHIFT);
      nreset_q <= (state_d != ST_CLEAR);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  config_bit_serializer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_data  (word_data),
    .load_count (load_count),
    .shift      (ser_shift),
    .bit_out    (config_out),
    .empty      (ser_empty)
  );

  assign word_ready    = ready_q;
  assign config_enable = enable_q;
  assign config_nreset = nreset_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with a serial-bit scoreboard and chain model.
module tb_config_loader;
  import config_loader_pkg::*;

  localparam int unsigned CL  = 36;
  localparam int unsigned WW  = 32;
  localparam int unsigned CC  = 2;
  localparam int unsigned NW  = words_needed(CL, WW);
  localparam int unsigned CL2 = 64;
  localparam int unsigned NW2 = words_needed(CL2, WW);

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start, abort, word_valid;
  logic [WW-1:0] word_data;
  logic word_ready, config_out, config_enable, config_nreset, busy, done;

  logic start2, valid2;
  logic [WW-1:0] data2;
  logic ready2, out2, en2, nres2, busy2, done2;

  always #5 clock = ~clock;

  config_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW), .CLEAR_CYCLES(CC)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .config_out(config_out), .config_enable(config_enable),
    .config_nreset(config_nreset), .busy(busy), .done(done)
  );

  config_loader #(.CHAIN_LENGTH(CL2), .WORD_WIDTH(WW), .CLEAR_CYCLES(CC)) dut64 (
    .clock(clock), .reset(reset), .start(start2), .abort(1'b0),
    .word_data(data2), .word_valid(valid2), .word_ready(ready2),
    .config_out(out2), .config_enable(en2),
    .config_nreset(nres2), .busy(busy2), .done(done2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic exp_q[$];
  logic q2[$];
  int unsigned bursts[$];
  int unsigned cur_burst = 0;
  int unsigned en_cycles = 0, done_cnt = 0;
  int unsigned en2_cycles = 0, done2_cnt = 0, bursts2 = 0;
  int unsigned rem;
  logic prev_en = 1'b0, prev_en2 = 1'b0;
  logic hold_start = 1'b0;
  logic [CL-1:0] chain = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream chain model and scoreboard consumer, sampled mid-cycle.
  always @(negedge clock) begin
    logic b;
    if (!config_nreset) chain = '0;
    else if (config_enable) begin
      chain = {chain[CL-2:0], config_out};
      en_cycles++;
      cur_burst++;
      if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'(1));
      else begin
        b = exp_q.pop_front();
        check("serial_bit", 64'(config_out), 64'(b));
      end
    end
    if (!config_enable && cur_burst != 0) begin
      bursts.push_back(cur_burst);
      cur_burst = 0;
    end
    if (done) begin
      done_cnt++;
      check("done_after_last_enable", 64'(prev_en), 64'(1));
    end
    prev_en = config_enable;

    if (en2) begin
      en2_cycles++;
      if (!prev_en2) bursts2++;
      if (q2.size() == 0) check("sb64_underflow", 64'(q2.size()), 64'(1));
      else begin
        b = q2.pop_front();
        check("serial_bit_64", 64'(out2), 64'(b));
      end
    end
    if (done2) done2_cnt++;
    prev_en2 = en2;
  end

  task automatic begin_load();
    int unsigned lowc = 0;
    rem = CL; en_cycles = 0; done_cnt = 0; bursts.delete();
    start = 1'b1;
    @(negedge clock);
    start = hold_start;
    for (int i = 0; i < 20 && !word_ready; i++) begin
      if (!config_nreset) lowc++;
      @(negedge clock);
    end
    check("clear_cycles", 64'(lowc), 64'(CC));
    check("ready_after_clear", 64'(word_ready), 64'(1));
  endtask

  task automatic send_word(input logic [WW-1:0] d, input int unsigned stall);
    int unsigned n;
    for (int i = 0; i < 200 && !word_ready; i++) @(negedge clock);
    check("ready_wait", 64'(word_ready), 64'(1));
    for (int unsigned s = 0; s < stall; s++) begin
      @(negedge clock);
      check("stall_ready_held", 64'(word_ready), 64'(1));
      check("stall_no_enable", 64'(config_enable), 64'(0));
    end
    n = (rem < WW) ? rem : WW;
    for (int unsigned k = 0; k < n; k++) exp_q.push_back(d[k]);
    rem -= n;
    word_valid = 1'b1;
    word_data  = d;
    @(negedge clock);
    word_valid = 1'b0;
    word_data  = $urandom();
  endtask

  task automatic finish_load(input logic [CL-1:0] stream);
    logic [CL-1:0] exp_chain;
    for (int i = 0; i < 200 && !done; i++) @(negedge clock);
    check("done_seen", 64'(done), 64'(1));
    @(negedge clock);
    check("done_one_cycle", 64'(done), 64'(0));
    check("busy_idle_after_done", 64'(busy), 64'(0));
    check("enable_cycles", 64'(en_cycles), 64'(CL));
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    for (int k = 0; k < CL; k++) exp_chain[CL-1-k] = stream[k];
    check("chain_contents", 64'(chain), 64'(exp_chain));
  endtask

  initial begin
    logic [WW-1:0] a, b, d;
    logic [CL-1:0] stream;
    start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
    start2 = 1'b0; valid2 = 1'b0; data2 = '0;
    a = 32'hDEADBEEF;
    b = 32'h0000_0005;
    stream = {b[CL-WW-1:0], a};

    #1 reset = 1'b1;
    #1;
    check("rst_config_out", 64'(config_out), 64'(0));
    check("rst_config_enable", 64'(config_enable), 64'(0));
    check("rst_config_nreset", 64'(config_nreset), 64'(0));
    check("rst_word_ready", 64'(word_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_nreset_high", 64'(config_nreset), 64'(1));
    check("idle_not_busy", 64'(busy), 64'(0));

    // Basic two-word load
    begin_load();
    send_word(a, 0);
    send_word(b, 0);
    finish_load(stream);
    check("burst_count", 64'(bursts.size()), 64'(NW));
    check("burst0_len", 64'(bursts[0]), 64'(32));
    check("burst1_len", 64'(bursts[1]), 64'(4));

    // Host stall in LOAD
    begin_load();
    send_word(a, 5);
    send_word(b, 3);
    finish_load(stream);

    // Abort during bit 10 of word 0, then a clean reload
    begin_load();
    send_word(a, 0);
    repeat (10) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_enable_low", 64'(config_enable), 64'(0));
    check("abort_busy_low", 64'(busy), 64'(0));
    check("abort_ready_low", 64'(word_ready), 64'(0));
    @(negedge clock);
    check("abort_bits_sent", 64'(en_cycles), 64'(11));
    exp_q.delete();
    repeat (5) @(negedge clock);
    check("abort_no_done", 64'(done_cnt), 64'(0));
    begin_load();
    send_word(a, 0);
    send_word(b, 0);
    finish_load(stream);

    // Asynchronous reset between edges mid-SHIFT
    begin_load();
    send_word(a, 0);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_config_out", 64'(config_out), 64'(0));
    check("midrst_config_enable", 64'(config_enable), 64'(0));
    check("midrst_config_nreset", 64'(config_nreset), 64'(0));
    check("midrst_word_ready", 64'(word_ready), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("midrst_nreset_after", 64'(config_nreset), 64'(1));
    check("midrst_no_done", 64'(done_cnt), 64'(0));

    // Start held through an entire load
    hold_start = 1'b1;
    begin_load();
    send_word(b, 0);
    send_word(a, 0);
    finish_load({a[CL-WW-1:0], b});
    @(negedge clock);
    check("held_restart_busy", 64'(busy), 64'(1));
    check("held_restart_clear", 64'(config_nreset), 64'(0));
    hold_start = 1'b0;
    start = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("held_abort_idle", 64'(busy2 | busy), 64'(0));

    // 64-bit chain: two full words
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 200 && !ready2; i++) @(negedge clock);
      check("ready64_wait", 64'(ready2), 64'(1));
      d = (w == 0) ? 32'h0123_4567 : 32'h89AB_CDEF;
      for (int k = 0; k < WW; k++) q2.push_back(d[k]);
      valid2 = 1'b1;
      data2  = d;
      @(negedge clock);
      valid2 = 1'b0;
      data2  = $urandom();
    end
    for (int i = 0; i < 200 && !done2; i++) @(negedge clock);
    check("done64_seen", 64'(done2), 64'(1));
    @(negedge clock);
    check("enable64_cycles", 64'(en2_cycles), 64'(CL2));
    check("burst64_count", 64'(bursts2), 64'(NW2));
    check("done64_pulses", 64'(done2_cnt), 64'(1));
    check("sb64_drained", 64'(q2.size()), 64'(0));
    check("idle64_no_ready", 64'(ready2), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
